// File: rtl/ysyx_rob_pkg.sv
// ysyx_rob_pkg: shared types and helpers for the reorder buffer.
//   rob_state_t : per-entry lifecycle (FREE -> EX on dispatch -> WB on result)
//   TAG_NONE    : tag value meaning "no producer"
//   tag2idx     : ROB tag (index+1) back to entry index
package ysyx_rob_pkg;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    EX   = 2'd1,
    WB   = 2'd2
  } rob_state_t;

  localparam int TAG_NONE = 0;

  function automatic int tag2idx(input int tag);
    return tag - 1;
  endfunction

endpackage

// File: rtl/ysyx_rob_wbsel.sv
// ysyx_rob_wbsel: finds the lowest-index writeback port carrying a given tag.
//   tag_i    in  tag to look for (TAG_NONE never matches)
//   wb_valid in  per-port result strobe
//   wb_tag   in  per-port tag, packed port-major
//   hit      out some valid port carries tag_i
//   port     out index of the lowest matching port (0 when no hit)
module ysyx_rob_wbsel
  import ysyx_rob_pkg::*;
#(
  parameter int WB_PORTS = 2,
  parameter int TAGW     = 4,
  parameter int PW       = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1
) (
  input  logic [TAGW-1:0]          tag_i,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*TAGW-1:0] wb_tag,
  output logic                     hit,
  output logic [PW-1:0]            port
);

  // Scan from the top so the lowest matching port is the last one written.
  always_comb begin
    hit  = 1'b0;
    port = '0;
    for (int p = WB_PORTS - 1; p >= 0; p--) begin
      if (wb_valid[p] && (tag_i != TAGW'(TAG_NONE)) && (wb_tag[p*TAGW +: TAGW] == tag_i)) begin
        hit  = 1'b1;
        port = PW'(p);
      end
    end
  end

endmodule

// File: rtl/ysyx_rob_mp.sv
// ysyx_rob_mp: reorder buffer with register rename table.
//   clock/reset         : clock, synchronous active-high reset
//   disp_*              : one micro-op per cycle in; disp_tag is the tag it gets
//   rs1/rs2 -> rs*_*    : combinational operand lookup (tag or forwarded value)
//   wb_*                : WB_PORTS result ports, matched by tag
//   cm_*                : in-order retirement under valid/ready
//   flush_valid/pc      : one-cycle flush after a mispredicted commit
//   count               : occupancy
module ysyx_rob_mp
  import ysyx_rob_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ROB_SIZE = 8,
  parameter int REG_NUM  = 16,
  parameter int WB_PORTS = 2,
  parameter int TAGW     = $clog2(ROB_SIZE) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [4:0]               disp_rd,
  input  logic [XLEN-1:0]          disp_pc,
  input  logic [XLEN-1:0]          disp_pnpc,
  output logic [TAGW-1:0]          disp_tag,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic [TAGW-1:0]          rs1_tag,
  output logic [TAGW-1:0]          rs2_tag,
  output logic                     rs1_fwd,
  output logic                     rs2_fwd,
  output logic [XLEN-1:0]          rs1_val,
  output logic [XLEN-1:0]          rs2_val,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*TAGW-1:0] wb_tag,
  input  logic [WB_PORTS*XLEN-1:0] wb_result,
  input  logic [WB_PORTS*XLEN-1:0] wb_npc,
  input  logic [WB_PORTS-1:0]      wb_ctrl,
  output logic                     cm_valid,
  input  logic                     cm_ready,
  output logic [4:0]               cm_rd,
  output logic [XLEN-1:0]          cm_pc,
  output logic [XLEN-1:0]          cm_result,
  output logic                     flush_valid,
  output logic [XLEN-1:0]          flush_pc,
  output logic [$clog2(ROB_SIZE):0] count
);

  localparam int IW  = $clog2(ROB_SIZE);
  localparam int CW  = IW + 1;
  localparam int RIW = $clog2(REG_NUM);
  localparam int PW  = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;

  rob_state_t      st_q   [ROB_SIZE], st_d   [ROB_SIZE];
  logic [4:0]      rd_q   [ROB_SIZE], rd_d   [ROB_SIZE];
  logic [XLEN-1:0] pc_q   [ROB_SIZE], pc_d   [ROB_SIZE];
  logic [XLEN-1:0] pnpc_q [ROB_SIZE], pnpc_d [ROB_SIZE];
  logic [XLEN-1:0] res_q  [ROB_SIZE], res_d  [ROB_SIZE];
  logic [XLEN-1:0] npc_q  [ROB_SIZE], npc_d  [ROB_SIZE];
  logic            ctrl_q [ROB_SIZE], ctrl_d [ROB_SIZE];
  logic [TAGW-1:0] rf_tag_q [REG_NUM], rf_tag_d [REG_NUM];
  logic [REG_NUM-1:0] rf_busy_q, rf_busy_d;
  logic [IW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            flush_q, flush_d;
  logic [XLEN-1:0] flush_pc_q, flush_pc_d;

  logic            disp_fire, cm_fire, mispred;
  logic [TAGW-1:0] head_tag;
  logic [RIW-1:0]  head_ridx, disp_ridx;
  logic [WB_PORTS-1:0] wb_vld_g;

  logic [ROB_SIZE-1:0] ent_hit;
  logic [PW-1:0]       ent_port [ROB_SIZE];
  logic [4:0]          rs_a     [2];
  logic [RIW-1:0]      rs_idx   [2];
  logic [1:0]          byp_hit;
  logic [PW-1:0]       byp_port [2];
  logic [TAGW-1:0]     lk_tag   [2];
  logic [1:0]          lk_fwd;
  logic [XLEN-1:0]     lk_val   [2];

  // Results arriving during the flush cycle belong to squashed work.
  assign wb_vld_g = flush_q ? '0 : wb_valid;

  for (genvar i = 0; i < ROB_SIZE; i++) begin : g_ent_sel
    ysyx_rob_wbsel #(.WB_PORTS(WB_PORTS), .TAGW(TAGW), .PW(PW)) u_sel (
      .tag_i(TAGW'(i + 1)), .wb_valid(wb_vld_g), .wb_tag(wb_tag),
      .hit(ent_hit[i]), .port(ent_port[i])
    );
  end

  assign rs_a[0] = rs1;
  assign rs_a[1] = rs2;

  for (genvar s = 0; s < 2; s++) begin : g_byp_sel
    assign rs_idx[s] = rs_a[s][RIW-1:0];
    ysyx_rob_wbsel #(.WB_PORTS(WB_PORTS), .TAGW(TAGW), .PW(PW)) u_sel (
      .tag_i(rf_tag_q[rs_idx[s]]), .wb_valid(wb_vld_g), .wb_tag(wb_tag),
      .hit(byp_hit[s]), .port(byp_port[s])
    );
  end

  assign disp_ready  = (count_q != CW'(ROB_SIZE)) && !flush_q;
  assign disp_tag    = TAGW'(tail_q) + TAGW'(1);
  assign cm_valid    = (st_q[head_q] == WB) && !flush_q;
  assign cm_rd       = rd_q[head_q];
  assign cm_pc       = pc_q[head_q];
  assign cm_result   = res_q[head_q];
  assign flush_valid = flush_q;
  assign flush_pc    = flush_pc_q;
  assign count       = count_q;

  assign disp_fire = disp_valid && disp_ready;
  assign cm_fire   = cm_valid && cm_ready;
  assign mispred   = cm_fire && ctrl_q[head_q] && (npc_q[head_q] != pnpc_q[head_q]);
  assign head_tag  = TAGW'(head_q) + TAGW'(1);
  assign head_ridx = rd_q[head_q][RIW-1:0];
  assign disp_ridx = disp_rd[RIW-1:0];

  always_comb begin
    st_d       = st_q;
    rd_d       = rd_q;
    pc_d       = pc_q;
    pnpc_d     = pnpc_q;
    res_d      = res_q;
    npc_d      = npc_q;
    ctrl_d     = ctrl_q;
    rf_tag_d   = rf_tag_q;
    rf_busy_d  = rf_busy_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q + CW'(disp_fire) - CW'(cm_fire);
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;

    for (int i = 0; i < ROB_SIZE; i++) begin
      if (st_q[i] == EX && ent_hit[i]) begin
        st_d[i]   = WB;
        res_d[i]  = wb_result[int'(ent_port[i])*XLEN +: XLEN];
        npc_d[i]  = wb_npc[int'(ent_port[i])*XLEN +: XLEN];
        ctrl_d[i] = wb_ctrl[ent_port[i]];
      end
    end

    if (cm_fire) begin
      st_d[head_q] = FREE;
      head_d       = head_q + IW'(1);
      // Only the youngest writer of rd may release it.
      if (rd_q[head_q] != 5'd0 && rf_tag_q[head_ridx] == head_tag)
        rf_busy_d[head_ridx] = 1'b0;
    end

    // Applied after the commit release so a same-cycle rename keeps rd busy.
    if (disp_fire) begin
      st_d[tail_q]   = EX;
      rd_d[tail_q]   = disp_rd;
      pc_d[tail_q]   = disp_pc;
      pnpc_d[tail_q] = disp_pnpc;
      tail_d         = tail_q + IW'(1);
      if (disp_rd != 5'd0) begin
        rf_busy_d[disp_ridx] = 1'b1;
        rf_tag_d[disp_ridx]  = disp_tag;
      end
    end

    if (mispred) begin
      for (int i = 0; i < ROB_SIZE; i++) st_d[i] = FREE;
      rf_busy_d  = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      flush_d    = 1'b1;
      flush_pc_d = npc_q[head_q];
    end
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      lk_tag[s] = TAGW'(TAG_NONE);
      lk_fwd[s] = 1'b0;
      lk_val[s] = '0;
      if (rs_a[s] != 5'd0 && rf_busy_q[rs_idx[s]]) begin
        if (st_q[IW'(tag2idx(int'(rf_tag_q[rs_idx[s]])))] == WB) begin
          lk_fwd[s] = 1'b1;
          lk_val[s] = res_q[IW'(tag2idx(int'(rf_tag_q[rs_idx[s]])))];
        end else if (byp_hit[s]) begin
          lk_fwd[s] = 1'b1;
          lk_val[s] = wb_result[int'(byp_port[s])*XLEN +: XLEN];
        end else begin
          lk_tag[s] = rf_tag_q[rs_idx[s]];
        end
      end
    end
  end

  assign rs1_tag = lk_tag[0];
  assign rs2_tag = lk_tag[1];
  assign rs1_fwd = lk_fwd[0];
  assign rs2_fwd = lk_fwd[1];
  assign rs1_val = lk_val[0];
  assign rs2_val = lk_val[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      rf_busy_q  <= '0;
      for (int i = 0; i < ROB_SIZE; i++) st_q[i] <= FREE;
      for (int r = 0; r < REG_NUM; r++) rf_tag_q[r] <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
      rf_busy_q  <= rf_busy_d;
      for (int i = 0; i < ROB_SIZE; i++) st_q[i] <= st_d[i];
      for (int r = 0; r < REG_NUM; r++) rf_tag_q[r] <= rf_tag_d[r];
    end
  end

  // Payload is only meaningful while the entry is not FREE, so no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      rd_q[i]   <= rd_d[i];
      pc_q[i]   <= pc_d[i];
      pnpc_q[i] <= pnpc_d[i];
      res_q[i]  <= res_d[i];
      npc_q[i]  <= npc_d[i];
      ctrl_q[i] <= ctrl_d[i];
    end
  end

endmodule

// File: doc/ysyx_rob_mp.md
Name: ysyx_rob_mp

Overview:
- Parametrised reorder buffer with a register-status (rename) table for the out-of-order backend.
- Sits between the issue/dispatch stage and the writeback/regfile stage.
- Accepts one dispatched micro-op per cycle and takes results from WB_PORTS functional units in the same cycle.
- Resolves source operands (value or tag), commits in order under a commit handshake, and raises a one-cycle flush with a redirect PC on a mispredicted commit.

Parameters:
- XLEN, 32: datapath width.
- ROB_SIZE, 8: entry count; must be a power of two, ≥2.
- REG_NUM, 16: architectural registers tracked; the index uses the low $clog2(REG_NUM) bits of rd/rs.
- WB_PORTS, 2: number of parallel result ports, ≥1.
- TAGW, $clog2(ROB_SIZE)+1: tag width. Tag = index+1; tag 0 means "no producer".

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  ROB can accept an entry this cycle.
- disp_rd  in  5  destination register; 0 = none.
- disp_pc  in  XLEN  instruction PC.
- disp_pnpc  in  XLEN  predicted next PC.
- disp_tag  out  TAGW  tag assigned to the entry at tail (tail+1).
- rs1, rs2  in  5  source lookup indices.
- rs1_tag, rs2_tag  out  TAGW  pending producer tag; 0 if the value is available.
- rs1_fwd, rs2_fwd  out  1  operand taken from the ROB or a WB port (not the regfile).
- rs1_val, rs2_val  out  XLEN  forwarded value, valid when *_fwd=1.
- wb_valid  in  WB_PORTS  per-port result strobe.
- wb_tag  in  WB_PORTS*TAGW  per-port target tag.
- wb_result  in  WB_PORTS*XLEN  per-port result.
- wb_npc  in  WB_PORTS*XLEN  per-port resolved next PC.
- wb_ctrl  in  WB_PORTS  entry is control flow, so npc must be checked.
- cm_valid  out  1  head entry ready to retire.
- cm_ready  in  1  writeback accepts the retirement.
- cm_rd  out  5  head destination register.
- cm_pc  out  XLEN  head PC.
- cm_result  out  XLEN  head result.
- flush_valid  out  1  one-cycle pipeline flush.
- flush_pc  out  XLEN  redirect target.
- count  out  $clog2(ROB_SIZE)+1  occupancy.

Behaviour:
- Entry state:
  - Each entry is FREE, EX or WB, with fields rd, pc, pnpc, result, npc, ctrl.
  - head and tail pointers wrap mod ROB_SIZE.
- Reset (synchronous, at the clock edge with reset=1):
  - head=tail=0, count=0, all entries FREE, rename table all not-busy.
  - Outputs after reset: flush_valid=0, cm_valid=0, disp_ready=1, disp_tag=1.
- disp_ready = (count<ROB_SIZE) && !flush_valid.
- Dispatch fire = disp_valid && disp_ready. On the edge:
  - Entry[tail] becomes EX and captures pc, pnpc and rd.
  - tail is incremented.
  - If rd!=0: rf_busy[rd]=1 and rf_tag[rd]=tail+1.
- Writeback:
  - A wb_valid port whose tag targets an EX entry moves that entry to WB on the edge and stores result, npc and ctrl.
  - A port targeting a FREE or WB entry, or carrying tag 0, is ignored.
  - If two ports carry the same tag in one cycle, the lowest-index port wins.
  - Result latency is one edge; the entry can commit in the next cycle.
- Operand lookup (combinational, per source; x0 always returns tag=0, fwd=0):
  - Not busy: tag=0, fwd=0.
  - Busy and producer in WB: tag=0, fwd=1, val = ROB result.
  - Busy, producer in EX, and a same-cycle wb port matches the tag: tag=0, fwd=1, val = that port's result (lowest matching port).
  - Otherwise: tag = rf_tag, fwd=0.
- Commit:
  - cm_valid = head entry is WB && !flush_valid.
  - Commit fire = cm_valid && cm_ready. On the edge: head entry becomes FREE and head is incremented.
  - rf_busy[rd] is cleared only if rf_tag[rd]==head+1 and no same-cycle dispatch targets the same rd.
  - count is unchanged when dispatch and commit fire together.
- Mispredict:
  - Condition: commit fire && ctrl && npc!=pnpc.
  - On that edge, retirement completes (cm_* seen by writeback), then all entries go FREE, head=tail=0, count=0 and the rename table clears.
  - flush_valid=1 for exactly the next cycle with flush_pc = that npc.
  - Any same-cycle dispatch or writeback is discarded.
  - During the flush cycle: disp_ready=0, cm_valid=0, wb ignored.
- Full: at count==ROB_SIZE, disp_ready=0; a simultaneous commit frees a slot only from the next cycle.
- Empty: count==0 gives cm_valid=0.
- Reset asserted mid-operation overrides every other event.

Decomposition:
- Shared package (ysyx_rob_pkg):
  - rob_state_t {FREE, EX, WB}.
  - TAG_NONE=0.
  - A function to convert tag to index.
- Sub-module ysyx_rob_wbsel: per-tag priority match across WB_PORTS, reused by writeback capture and operand bypass.

Test Plan:
1. Reset, then dispatch rd=5 pc=0x100 → disp_tag=1. Lookup rs1=5 → rs1_tag=1, fwd=0. wb port0 tag=1 result=0xAB the same cycle → rs1_fwd=1, val=0xAB. Next cycle cm_valid=1, cm_result=0xAB.
2. Fill 8 entries with no commit → disp_ready=0 and count=8. Commit one with dispatch held → next cycle disp_ready=1 and tail wraps to index 0 (tag=1).
3. Dispatch tags 1 and 2 both to rd=3. Commit tag 1 → rf_busy[3] stays set and rs tag=2. Commit tag 2 while a dispatch to rd=3 is accepted → rs tag = new tag.
4. Port0 and port1 both write tag=2 in one cycle (0x11 and 0x22) → stored result 0x11. wb to a FREE tag → no state change.
5. ctrl entry pc=0x200, pnpc=0x204, npc=0x300 commits → next cycle flush_valid=1, flush_pc=0x300, count=0, disp_ready=0; the cycle after, disp_ready=1 and disp_tag=1.
6. Reset asserted while 4 entries are in flight and wb_valid=1 → next cycle count=0, cm_valid=0, all rs lookups tag=0.
